lcd_timing_driver: RTL and testbench
====================================

# lcd_timing_driver

Pixel-clock timing generator and pixel output stage for the parallel RGB LCD, directly downstream of the colour-bar/pattern generator. It produces the panel's horizontal and vertical sync, data-enable, backlight, reset and pixel clock. It also issues per-pixel coordinate requests to the upstream pattern stage, which answers with 24-bit RGB one cycle later. It instantiates no clocking resources: the pixel clock is supplied already divided.

## Interface
- H_SYNC, 128, hsync pulse width in pixel clocks
- H_BACK, 88, horizontal back porch
- H_DISP, 800, active pixels per line
- H_FRONT, 40, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- CNT_W, 11, width of counters and coordinate outputs

Ports (clock and reset first):
- lcd_pclk  in  1  pixel clock; every register in the block runs on it
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- pixel_data  in  24  RGB888 from upstream, valid the cycle after data_req
- data_req  out  1  request for the pixel at pixel_xpos/pixel_ypos
- pixel_xpos  out  CNT_W  requested column, 0..H_DISP-1; 0 when data_req=0
- pixel_ypos  out  CNT_W  requested row, 0..V_DISP-1; 0 when data_req=0
- lcd_de  out  1  data enable
- lcd_hs  out  1  hsync, active-low
- lcd_vs  out  1  vsync, active-low
- lcd_bl  out  1  backlight enable, constant 1
- lcd_clk  out  1  equals lcd_pclk
- lcd_rst  out  1  equals sys_rst_n
- lcd_rgb  out  24  pixel_data while lcd_de=1, else 24'h0

## Operation
- Derived values: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (1056); V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (525); H_START = H_SYNC+H_BACK; V_START = V_SYNC+V_BACK.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only on the cycle where h_cnt wraps. It counts 0..V_TOTAL-1 and wraps to 0 when both counters are at terminal count on the same cycle.
- lcd_hs = 0 while h_cnt < H_SYNC.
- lcd_vs = 0 while v_cnt < V_SYNC.
- lcd_de = 1 when H_START ≤ h_cnt < H_START+H_DISP and V_START ≤ v_cnt < V_START+V_DISP.
- data_req uses the same window as lcd_de, shifted one clock earlier in h_cnt only: H_START-1 ≤ h_cnt < H_START+H_DISP-1, with the same v_cnt window. It never crosses a line boundary.
- pixel_xpos = h_cnt-(H_START-1) and pixel_ypos = v_cnt-V_START while data_req=1; both are 0 otherwise.
- Upstream contract: upstream registers pixel_data from the coordinates, so the pixel for column x appears exactly when lcd_de is high for column x. This block adds no data buffering.
- Reset: h_cnt = v_cnt = 0. Resulting output values: lcd_hs=0, lcd_vs=0, lcd_de=0, data_req=0, lcd_rgb=0, lcd_bl=1, lcd_rst=0.
- Reset asserted mid-frame: counters clear immediately. After release, the frame restarts from h=0, v=0, and no partial line is emitted.

## Timing
- Counters are registered. hs, vs, de, data_req and the coordinates are combinational decodes of the counters, glitch-free relative to lcd_pclk sampling.
- Request-to-display latency is exactly 1 clock.
- Per line: H_DISP data_req pulses and H_DISP lcd_de pulses, each run contiguous.
- Frame period: H_TOTAL×V_TOTAL clocks, i.e. 554400 clocks for the defaults.

## Configuration
- LCD_TIMING_DE_MODE_EN defined: lcd_hs and lcd_vs are tied to 1 for panels driven in DE-only mode. Counters, lcd_de, data_req and the coordinates are unchanged.
- Undefined: HV sync mode, as described above.

## Structure
- Shared package lcd_timing_pkg holds:
  - per-panel timing constant sets (4.3" 480×272, 7" 800×480, 7" 1024×600) used to override the parameters;
  - the localparams H_TOTAL, V_TOTAL, H_START and V_START as functions.
- One sub-module, lcd_timing_cnt: a generic wrap counter with enable, terminal-count output and async active-low clear. It is instantiated twice, for horizontal and vertical.

## Test plan
All scenarios use small parameters: H_SYNC=2, H_BACK=3, H_DISP=4, H_FRONT=1, V_SYNC=1, V_BACK=1, V_DISP=2, V_FRONT=1 (H_TOTAL=10, V_TOTAL=5).
- Reset release → lcd_hs=0 for 2 clocks, then 1 for 8; lcd_vs=0 for the first 10 clocks; lcd_de=0 throughout lines 0–1.
- Line 2 → data_req=1 at h_cnt 4..7 with pixel_xpos 0,1,2,3 and pixel_ypos 0; lcd_de=1 at h_cnt 5..8.
- Upstream model returning {ypos,xpos} registered → lcd_rgb shows 0x000000..0x000003 on line 2 and 0x000100..0x000103 on line 3; 0 elsewhere.
- Run 3 frames → v_cnt wraps after 50 clocks; lcd_vs low exactly once per 50 clocks; total lcd_de count = 8 per frame.
- Assert sys_rst_n low at h_cnt=6 of line 3 → lcd_de and lcd_rgb drop to 0 immediately; after release, first lcd_de occurs 25 clocks later, at line 2, h_cnt 5.
- Compile with LCD_TIMING_DE_MODE_EN → lcd_hs=lcd_vs=1 constantly; lcd_de waveform identical to the HV-mode run.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and helpers for the parallel RGB LCD timing driver.
// Panel sets below are meant for overriding lcd_timing_driver parameters.
package lcd_timing_pkg;

    // One panel's complete horizontal/vertical timing description
    typedef struct packed {
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] h_disp;
        logic [15:0] h_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
        logic [15:0] v_disp;
        logic [15:0] v_front;
    } lcd_timing_t;

    // 4.3" 480x272 panel
    localparam lcd_timing_t TIMING_4P3_480X272 = '{
        h_sync: 16'd41,  h_back: 16'd2,   h_disp: 16'd480,  h_front: 16'd2,
        v_sync: 16'd10,  v_back: 16'd2,   v_disp: 16'd272,  v_front: 16'd2
    };

    // 7" 800x480 panel (the block defaults)
    localparam lcd_timing_t TIMING_7P0_800X480 = '{
        h_sync: 16'd128, h_back: 16'd88,  h_disp: 16'd800,  h_front: 16'd40,
        v_sync: 16'd2,   v_back: 16'd33,  v_disp: 16'd480,  v_front: 16'd10
    };

    // 7" 1024x600 panel
    localparam lcd_timing_t TIMING_7P0_1024X600 = '{
        h_sync: 16'd20,  h_back: 16'd140, h_disp: 16'd1024, h_front: 16'd160,
        v_sync: 16'd3,   v_back: 16'd20,  v_disp: 16'd600,  v_front: 16'd12
    };

    // Full period of one axis (line length or frame height)
    function automatic int unsigned calc_total(input int unsigned sync,
                                               input int unsigned back,
                                               input int unsigned disp,
                                               input int unsigned front);
        return sync + back + disp + front;
    endfunction

    // First active count of one axis
    function automatic int unsigned calc_start(input int unsigned sync,
                                               input int unsigned back);
        return sync + back;
    endfunction

endpackage

// File: rtl/lcd_timing_cnt.sv
// Generic wrap counter: counts 0..MAX while enabled, then wraps to 0.
// tc_c flags the terminal count combinationally, independent of enable.
module lcd_timing_cnt
    import lcd_timing_pkg::*;
#(
    parameter int unsigned W   = 11,
    parameter int unsigned MAX = 1055
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Terminal-count decode
    assign tc_c = (cnt == MAX_V);

    // Counter register with async clear and wrap at MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/lcd_timing_driver.sv
// Pixel-clock timing generator and pixel output stage for a parallel RGB LCD.
// Issues coordinate requests one clock ahead of data-enable so that the
// upstream pattern stage's registered RGB lines up with lcd_de.
// Build option: LCD_TIMING_DE_MODE_EN ties lcd_hs/lcd_vs high (DE-only panels).
module lcd_timing_driver
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = 128,
    parameter int unsigned H_BACK  = 88,
    parameter int unsigned H_DISP  = 800,
    parameter int unsigned H_FRONT = 40,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             lcd_pclk,
    input  logic             sys_rst_n,
    input  logic [23:0]      pixel_data,
    output logic             data_req,
    output logic [CNT_W-1:0] pixel_xpos,
    output logic [CNT_W-1:0] pixel_ypos,
    output logic             lcd_de,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_bl,
    output logic             lcd_clk,
    output logic             lcd_rst,
    output logic [23:0]      lcd_rgb
);

    localparam int unsigned H_TOTAL = calc_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int unsigned V_TOTAL = calc_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam int unsigned H_START = calc_start(H_SYNC, H_BACK);
    localparam int unsigned V_START = calc_start(V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] DE_H_BEG  = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] DE_H_END  = CNT_W'(H_START + H_DISP);
    localparam logic [CNT_W-1:0] REQ_H_BEG = CNT_W'(H_START - 1);
    localparam logic [CNT_W-1:0] REQ_H_END = CNT_W'(H_START + H_DISP - 1);
    localparam logic [CNT_W-1:0] V_BEG     = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_START + V_DISP);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_tc_c;
    logic             v_tc_unused;
    logic             v_active_c;

    // Horizontal counter: free-running across the whole line
    lcd_timing_cnt #(
        .W   (CNT_W),
        .MAX (H_TOTAL - 1)
    ) u_h_cnt (
        .clk   (lcd_pclk),
        .rst_n (sys_rst_n),
        .en    (1'b1),
        .cnt   (h_cnt),
        .tc_c  (h_tc_c)
    );

    // Vertical counter: steps once per line, wraps with the last line's end
    lcd_timing_cnt #(
        .W   (CNT_W),
        .MAX (V_TOTAL - 1)
    ) u_v_cnt (
        .clk   (lcd_pclk),
        .rst_n (sys_rst_n),
        .en    (h_tc_c),
        .cnt   (v_cnt),
        .tc_c  (v_tc_unused)
    );

    // Timing decodes: de window, request window one pixel earlier, coordinates
    always_comb begin
        v_active_c = 1'b0;
        lcd_de     = 1'b0;
        data_req   = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        lcd_rgb    = 24'h0;

        v_active_c = (v_cnt >= V_BEG) && (v_cnt < V_END);
        lcd_de     = v_active_c && (h_cnt >= DE_H_BEG) && (h_cnt < DE_H_END);
        data_req   = v_active_c && (h_cnt >= REQ_H_BEG) && (h_cnt < REQ_H_END);
        if (data_req) begin
            pixel_xpos = h_cnt - REQ_H_BEG;
            pixel_ypos = v_cnt - V_BEG;
        end
        if (lcd_de) begin
            lcd_rgb = pixel_data;
        end
    end

    // Sync outputs: active-low pulses, or held high for DE-only panels
`ifdef LCD_TIMING_DE_MODE_EN
    assign lcd_hs = 1'b1;
    assign lcd_vs = 1'b1;
`else
    assign lcd_hs = (h_cnt >= HS_END);
    assign lcd_vs = (v_cnt >= VS_END);
`endif

    // Panel control pass-throughs
    assign lcd_bl  = 1'b1;
    assign lcd_clk = lcd_pclk;
    assign lcd_rst = sys_rst_n;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver with a small 10x5 raster.
// Build option mirrored from the design: LCD_TIMING_DE_MODE_EN.
module tb_lcd_timing_driver;

    localparam int unsigned CNT_W  = 11;
    localparam int          NCYC   = 150;
`ifdef LCD_TIMING_DE_MODE_EN
    localparam bit DE_MODE = 1'b1;
`else
    localparam bit DE_MODE = 1'b0;
`endif

    logic             lcd_pclk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [23:0]      pixel_data = 24'h0;
    logic             data_req;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic             lcd_de;
    logic             lcd_hs;
    logic             lcd_vs;
    logic             lcd_bl;
    logic             lcd_clk;
    logic             lcd_rst;
    logic [23:0]      lcd_rgb;

    int total = 0;
    int bad   = 0;

    lcd_timing_driver #(
        .H_SYNC (2), .H_BACK (3), .H_DISP (4), .H_FRONT (1),
        .V_SYNC (1), .V_BACK (1), .V_DISP (2), .V_FRONT (1),
        .CNT_W  (CNT_W)
    ) dut (
        .lcd_pclk   (lcd_pclk),
        .sys_rst_n  (sys_rst_n),
        .pixel_data (pixel_data),
        .data_req   (data_req),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .lcd_de     (lcd_de),
        .lcd_hs     (lcd_hs),
        .lcd_vs     (lcd_vs),
        .lcd_bl     (lcd_bl),
        .lcd_clk    (lcd_clk),
        .lcd_rst    (lcd_rst),
        .lcd_rgb    (lcd_rgb)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    // Upstream pattern stage: registers {ypos, xpos} from the request
    always @(posedge lcd_pclk) begin
        pixel_data <= {8'h00, pixel_ypos[7:0], pixel_xpos[7:0]};
    end

    typedef struct {
        int          cyc;
        logic        hs;
        logic        vs;
        logic        de;
        logic        req;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic        req;
        int          x;
        int          y;
        logic [23:0] rgb;
    } obs_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];
    obs_t obs  [NCYC];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic sample(input int n);
        obs[n].hs  = lcd_hs;
        obs[n].vs  = lcd_vs;
        obs[n].de  = lcd_de;
        obs[n].req = data_req;
        obs[n].x   = int'(pixel_xpos);
        obs[n].y   = int'(pixel_ypos);
        obs[n].rgb = lcd_rgb;
    endtask

    initial begin
        int hs_low, vs_low, vs_runs, req_cnt, wait_cnt;
        int de_frame [3];
        logic exp_hs, exp_vs;

        // cyc = v*10 + h;  de window h5..8, request h4..7, active lines 2..3
        vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[1]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[2]  = '{2,   1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[3]  = '{9,   1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[4]  = '{10,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[5]  = '{12,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[6]  = '{24,  1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 24'h000000};
        vecs[7]  = '{25,  1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 24'h000000};
        vecs[8]  = '{26,  1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 24'h000001};
        vecs[9]  = '{27,  1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 24'h000002};
        vecs[10] = '{28,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 24'h000003};
        vecs[11] = '{29,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[12] = '{34,  1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 24'h000000};
        vecs[13] = '{35,  1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 24'h000100};
        vecs[14] = '{38,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 24'h000103};
        vecs[15] = '{39,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[16] = '{40,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[17] = '{50,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000};
        vecs[18] = '{75,  1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 24'h000000};
        vecs[19] = '{138, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 24'h000103};

        // Reset state
        repeat (3) @(negedge lcd_pclk);
        #1;
        chk("rst_hs",  int'(lcd_hs),   DE_MODE ? 1 : 0);
        chk("rst_vs",  int'(lcd_vs),   DE_MODE ? 1 : 0);
        chk("rst_de",  int'(lcd_de),   0);
        chk("rst_req", int'(data_req), 0);
        chk("rst_rgb", int'(lcd_rgb),  0);
        chk("rst_bl",  int'(lcd_bl),   1);
        chk("rst_rst", int'(lcd_rst),  0);
        chk("rst_clk", int'(lcd_clk),  0);

        // Release and record three full frames
        sys_rst_n = 1'b1;
        #1;
        sample(0);
        for (int n = 1; n < NCYC; n++) begin
            @(negedge lcd_pclk);
            #1;
            sample(n);
        end

        // Table comparisons
        for (int i = 0; i < NVEC; i++) begin
            exp_hs = DE_MODE ? 1'b1 : vecs[i].hs;
            exp_vs = DE_MODE ? 1'b1 : vecs[i].vs;
            chk($sformatf("c%0d_hs", vecs[i].cyc),  int'(obs[vecs[i].cyc].hs),  int'(exp_hs));
            chk($sformatf("c%0d_vs", vecs[i].cyc),  int'(obs[vecs[i].cyc].vs),  int'(exp_vs));
            chk($sformatf("c%0d_de", vecs[i].cyc),  int'(obs[vecs[i].cyc].de),  int'(vecs[i].de));
            chk($sformatf("c%0d_req", vecs[i].cyc), int'(obs[vecs[i].cyc].req), int'(vecs[i].req));
            chk($sformatf("c%0d_x", vecs[i].cyc),   obs[vecs[i].cyc].x,         vecs[i].x);
            chk($sformatf("c%0d_y", vecs[i].cyc),   obs[vecs[i].cyc].y,         vecs[i].y);
            chk($sformatf("c%0d_rgb", vecs[i].cyc), int'(obs[vecs[i].cyc].rgb), int'(vecs[i].rgb));
        end

        // Aggregate counts over the three frames
        hs_low = 0; vs_low = 0; vs_runs = 0; req_cnt = 0;
        de_frame[0] = 0; de_frame[1] = 0; de_frame[2] = 0;
        for (int n = 0; n < NCYC; n++) begin
            if (!obs[n].hs) hs_low++;
            if (!obs[n].vs) vs_low++;
            if (!obs[n].vs && (n == 0 || obs[n-1].vs)) vs_runs++;
            if (obs[n].req) req_cnt++;
            if (obs[n].de) de_frame[n / 50]++;
        end
        chk("hs_low_cnt", hs_low,  DE_MODE ? 0 : 30);
        chk("vs_low_cnt", vs_low,  DE_MODE ? 0 : 30);
        chk("vs_runs",    vs_runs, DE_MODE ? 0 : 3);
        chk("req_cnt",    req_cnt, 24);
        chk("de_frame0",  de_frame[0], 8);
        chk("de_frame1",  de_frame[1], 8);
        chk("de_frame2",  de_frame[2], 8);

        // Mid-frame reset at line 3, h_cnt 6 (state 186 = 3*50 + 36)
        repeat (37) @(negedge lcd_pclk);
        #1;
        chk("mid_de_before", int'(lcd_de), 1);
        chk("mid_x_before",  int'(pixel_xpos), 2);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_de",  int'(lcd_de),     0);
        chk("mid_rgb", int'(lcd_rgb),    0);
        chk("mid_req", int'(data_req),   0);
        chk("mid_x",   int'(pixel_xpos), 0);
        chk("mid_rst", int'(lcd_rst),    0);
        repeat (2) @(negedge lcd_pclk);
        #1;
        sys_rst_n = 1'b1;
        #1;
        wait_cnt = 0;
        while (!lcd_de && wait_cnt < 100) begin
            @(negedge lcd_pclk);
            #1;
            wait_cnt++;
        end
        chk("restart_de_seen",  int'(lcd_de),     1);
        chk("restart_latency",  wait_cnt,         25);
        chk("restart_x",        int'(pixel_xpos), 1);
        chk("restart_rgb",      int'(lcd_rgb),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
